// File: rtl/channel_mux_pkg.sv
// Shared types and constants for the four-channel collecting multiplexer.
// CHANNEL_MUX_RR_EN selects round-robin arbitration; it is fixed priority otherwise.
package channel_mux_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/channel_multiplexer_rr_arbiter4.sv
// Four-way request search. With CHANNEL_MUX_RR_EN the search starts just after
// `last`; without it, the lowest select code wins and `last` is ignored.
module rr_arbiter4
    import channel_mux_pkg::*;
(
    input  logic [3:0] req,
    input  sel_t       last,
    output sel_t       gnt_idx,
    output logic       any
);

    assign any = |req;

`ifdef CHANNEL_MUX_RR_EN
    sel_t w_idx;
    logic w_found;

    // Rotating search: last+1, last+2, last+3, then last itself
    always_comb begin
        gnt_idx = SEL_A;
        w_found = 1'b0;
        w_idx   = SEL_A;
        for (int k = 1; k <= 4; k++) begin
            w_idx = last + k[1:0];
            if (!w_found && req[w_idx]) begin
                gnt_idx = w_idx;
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^last;

    // Fixed priority search: A > B > C > D
    always_comb begin
        if (req[0]) begin
            gnt_idx = SEL_A;
        end else if (req[1]) begin
            gnt_idx = SEL_B;
        end else if (req[2]) begin
            gnt_idx = SEL_C;
        end else begin
            gnt_idx = SEL_D;
        end
    end
`endif

endmodule

// File: rtl/channel_multiplexer.sv
// Registered 4-to-1 valid/ready collector with channel tag on the output.
// Define CHANNEL_MUX_RR_EN for round-robin; otherwise fixed priority A>B>C>D.
module channel_multiplexer
    import channel_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Enable,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [3:0]       valid,
    output logic [3:0]       ready,
    output logic [WIDTH-1:0] Y,
    output logic [1:0]       Y_sel,
    output logic             Y_valid,
    input  logic             Y_ready
);

    state_t           r_state;
    logic [WIDTH-1:0] r_y;
    sel_t             r_y_sel;
    sel_t             w_last;
    sel_t             w_gnt;
    logic             w_any;
    logic             w_load;
    logic [WIDTH-1:0] w_data;

`ifdef CHANNEL_MUX_RR_EN
    sel_t r_last;

    // Arbiter pointer moves only when a word is actually taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= SEL_D;
        end else if (w_load) begin
            r_last <= w_gnt;
        end else begin
            r_last <= r_last;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = SEL_D;
`endif

    rr_arbiter4 u_arb (
        .req     (valid),
        .last    (w_last),
        .gnt_idx (w_gnt),
        .any     (w_any)
    );

    // Gating with rst keeps ready low while the block is held in reset
    assign w_load = !rst && Enable && w_any && (r_state == EMPTY || Y_ready);
    assign ready  = w_load ? (4'b0001 << w_gnt) : 4'b0000;

    // Select the granted channel's data
    always_comb begin
        case (w_gnt)
            SEL_A:   w_data = A;
            SEL_B:   w_data = B;
            SEL_C:   w_data = C;
            SEL_D:   w_data = D;
            default: w_data = A;
        endcase
    end

    // Output word register and EMPTY/FULL state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_y     <= '0;
            r_y_sel <= SEL_A;
        end else if (w_load) begin
            r_state <= FULL;
            r_y     <= w_data;
            r_y_sel <= w_gnt;
        end else if (r_state == FULL && Y_ready) begin
            r_state <= EMPTY;
            r_y     <= r_y;
            r_y_sel <= r_y_sel;
        end else begin
            r_state <= r_state;
            r_y     <= r_y;
            r_y_sel <= r_y_sel;
        end
    end

    assign Y       = r_y;
    assign Y_sel   = r_y_sel;
    assign Y_valid = (r_state == FULL);

endmodule

// File: tb/tb_channel_multiplexer.sv
// Directed bench for channel_multiplexer with a queue-free behavioural model;
// expectations follow CHANNEL_MUX_RR_EN when it is defined.
module tb_channel_multiplexer;

    logic       clk;
    logic       rst;
    logic       Enable;
    logic [3:0] A, B, C, D;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] Y;
    logic [1:0] Y_sel;
    logic       Y_valid;
    logic       Y_ready;

    int n_checks;
    int n_fail;

    // Model state: whether a word is held, the word, its channel, last grant
    logic       m_full;
    logic [3:0] m_y;
    int         m_sel;
    int         m_last;

`ifdef CHANNEL_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    channel_multiplexer #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .Enable  (Enable),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .valid   (valid),
        .ready   (ready),
        .Y       (Y),
        .Y_sel   (Y_sel),
        .Y_valid (Y_valid),
        .Y_ready (Y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Which channel should win given the pending requests, -1 if none
    function automatic int model_grant(input logic [3:0] v, input int lst);
        int c;
        if (RR) begin
            for (int k = 1; k <= 4; k++) begin
                c = (lst + k) % 4;
                if (v[c]) return c;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (v[k]) return k;
            end
        end
        return -1;
    endfunction

    function automatic logic [3:0] chan_data(input int c);
        case (c)
            0: return A;
            1: return B;
            2: return C;
            default: return D;
        endcase
    endfunction

    function automatic logic model_load();
        return !rst && Enable && (model_grant(valid, m_last) >= 0) && (!m_full || Y_ready);
    endfunction

    // Model update on the active edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full <= 1'b0;
            m_y    <= 4'h0;
            m_sel  <= 0;
            m_last <= 3;
        end else if (model_load()) begin
            m_full <= 1'b1;
            m_y    <= chan_data(model_grant(valid, m_last));
            m_sel  <= model_grant(valid, m_last);
            m_last <= model_grant(valid, m_last);
        end else if (m_full && Y_ready) begin
            m_full <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [3:0] er;
        er = model_load() ? (4'b0001 << model_grant(valid, m_last)) : 4'b0000;
        check("cmp_ready", ready, er);
        check("cmp_Y_valid", Y_valid, m_full);
        check("cmp_Y_sel", Y_sel, m_sel);
        check("cmp_Y", Y, m_y);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; Enable = 1'b0; valid = 4'b0000; Y_ready = 1'b0;
        A = 4'h0; B = 4'h0; C = 4'h0; D = 4'h0;

        // Reset state
        @(negedge clk);
        check("reset_Y_valid", Y_valid, 1'b0);
        check("reset_Y", Y, 4'h0);
        check("reset_ready", ready, 4'b0000);
        step();
        rst = 1'b0;

        // Single channel C
        Enable = 1'b1; C = 4'h5; valid = 4'b0100; Y_ready = 1'b1;
        @(negedge clk);
        check("single_ready", ready, 4'b0100);
        step();
        valid = 4'b0000;
        @(negedge clk);
        check("single_Y", Y, 4'h5);
        check("single_Y_sel", Y_sel, 2'b10);
        check("single_Y_valid", Y_valid, 1'b1);
        step();
        @(negedge clk);
        check("single_drain", Y_valid, 1'b0);

        // Reset pulse while FULL holding 4'hA
        step();
        A = 4'hA; valid = 4'b0001; Y_ready = 1'b0;
        @(negedge clk);
        check("rstmid_ready", ready, 4'b0001);
        step();
        valid = 4'b0000;
        @(negedge clk);
        check("rstmid_Y_pre", Y, 4'hA);
        #1 rst = 1'b1;
        #1;
        check("rstmid_Y_valid", Y_valid, 1'b0);
        check("rstmid_Y", Y, 4'h0);
        check("rstmid_Y_sel", Y_sel, 2'b00);
        check("rstmid_ready0", ready, 4'b0000);
        step();
        rst = 1'b0;

        // All channels valid, consecutive grants
        A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4; valid = 4'b1111; Y_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("rr_Y_sel", Y_sel, RR ? (k % 4) : 0);
            check("rr_Y", Y, RR ? ((k % 4) + 1) : 1);
        end
        step();
        valid = 4'b0000;

        // Backpressure: hold 4'h3 while B waits
        step();
        C = 4'h3; valid = 4'b0100; Y_ready = 1'b0;
        step();
        valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready", ready, 4'b0000);
            check("bp_Y", Y, 4'h3);
            step();
        end
        Y_ready = 1'b1;
        @(negedge clk);
        check("bp_pass_ready", ready, 4'b0010);
        step();
        valid = 4'b0000;
        @(negedge clk);
        check("bp_Y_new", Y, 4'h2);
        check("bp_Y_sel_new", Y_sel, 2'b01);

        // Enable low drains without granting
        step();
        Enable = 1'b0; valid = 4'b1111;
        @(negedge clk);
        check("en_ready0", ready, 4'b0000);
        step();
        @(negedge clk);
        check("en_drained", Y_valid, 1'b0);
        check("en_ready1", ready, 4'b0000);
        step();
        Enable = 1'b1;
        @(negedge clk);
        check("en_resume", ready, RR ? 4'b0100 : 4'b0001);

        // Wrap: D sets last to 11, then A wins over D
        step();
        valid = 4'b1000;
        @(negedge clk);
        check("wrap_d_ready", ready, 4'b1000);
        step();
        valid = 4'b1001;
        @(negedge clk);
        check("wrap_a_ready", ready, 4'b0001);
        step();
        valid = 4'b1000;
        @(negedge clk);
        check("wrap_a_sel", Y_sel, 2'b00);
        check("wrap_d_ready2", ready, 4'b1000);
        step();
        valid = 4'b0000;
        @(negedge clk);
        check("wrap_d_sel", Y_sel, 2'b11);
        check("wrap_d_Y", Y, 4'h4);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_multiplexer.md
# channel_multiplexer

Registered 4-to-1 channel multiplexer: the collecting end of the four-channel demultiplexer path. It arbitrates among four valid/ready source channels (A–D), latches one word per cycle into a single output register, and presents it with the 2-bit channel select. A downstream demultiplexer driven by `Y_sel` can then steer the word back to its channel. It sits between four independent producers and one shared bus.

## Interface
- `WIDTH`, 4, data width of every channel and of `Y`
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `Enable`  input  1  when low, no new grants; a held word still drains
- `A`, `B`, `C`, `D`  input  WIDTH each  channel data, select codes 00/01/10/11
- `valid`  input  4  per-channel valid, bit i = channel with select code i
- `ready`  output  4  per-channel ready, one-hot or zero, combinational
- `Y`  output  WIDTH  registered output word
- `Y_sel`  output  2  select code of the channel that sourced `Y`
- `Y_valid`  output  1  `Y`/`Y_sel` hold a word
- `Y_ready`  input  1  downstream accepts when `Y_valid && Y_ready`

## Operation
- Two states: EMPTY (`Y_valid`=0) and FULL (`Y_valid`=1).
- `load` = `Enable && |valid && (state==EMPTY || Y_ready)`. Pass-through is allowed: in FULL with `Y_ready`=1, a new word loads in the same cycle the old one drains.
- On `load`: grant index g from the arbiter. `ready[g]`=1 in that cycle only, other bits 0. Next edge: `Y`←channel g data, `Y_sel`←g, state→FULL.
- FULL, `Y_ready`=1, no load → EMPTY. `Y` and `Y_sel` keep their last value, and `Y_valid`=0.
- FULL, `Y_ready`=0 → hold. `ready`=0, and `Y`/`Y_sel` are stable.
- `Enable`=0: `ready`=0 and no load. FULL still drains to EMPTY on `Y_ready`.
- Arbiter pointer `last` (2 bits) updates to g only on `load`. Search order is last+1, last+2, last+3, last, mod 4 (wrap 11→00).
- A source must hold data/valid until it sees `ready[i]`. The block never drops or duplicates a word.
- `rst` mid-transfer: the held word is discarded. No `ready` is asserted during reset.

## Timing
- Reset values: `Y`=0, `Y_sel`=00, `Y_valid`=0, state EMPTY, `last`=11 (channel A wins first). `ready`=0 while `rst`=1.
- Latency: `valid[i]` high at edge n with grant → `Y_valid`=1 after edge n+1 (1 cycle).
- Throughput: one word per cycle when `Y_ready` is held high.
- `ready` depends combinationally on `valid`, `Enable`, `Y_ready`, state and `last`. There is no combinational path from `valid` to `Y`.

## Configuration
- `CHANNEL_MUX_RR_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority A>B>C>D (lowest select code wins). `last` is removed, and all other behaviour is identical.

## Structure
- Package `channel_mux_pkg`: `WIDTH` default constant, `sel_t` (logic [1:0]), constants `SEL_A`=00, `SEL_B`=01, `SEL_C`=10, `SEL_D`=11, state enum `{EMPTY, FULL}`.
- One sub-module, `rr_arbiter4`: inputs `req[3:0]`, `last`; outputs `gnt_idx`, `any`. It contains the pointer search only. The pointer register stays in the parent, and the macro selects the fixed-priority variant inside it.

## Test plan
- Reset: `rst` pulsed mid-FULL with `Y`=4'hA → `Y_valid`=0, `Y`=0, `Y_sel`=00 immediately. After release, first grant with all valid goes to A.
- Single channel: C=4'h5, `valid`=0100, `Y_ready`=1 → `ready`=0100 for one cycle. Next cycle `Y`=5, `Y_sel`=10, `Y_valid`=1.
- Round-robin: all valid, A..D=1,2,3,4, `Y_ready`=1 → `Y_sel` sequence 00,01,10,11,00 on consecutive cycles. Without the macro: 00,00,00.
- Backpressure: FULL with `Y`=4'h3, `Y_ready`=0 for 3 cycles, B valid → `ready`=0 and `Y` stable. On `Y_ready`=1, B loads the same cycle and `Y`=B next cycle.
- Enable low: `Enable`=0, all valid, FULL, `Y_ready`=1 → drains to EMPTY and no `ready` asserts. `Enable`=1 → grant resumes from `last`+1.
- Wrap: `last`=11, `valid`=1001 → A granted (00), then D (11).
